// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one cyc/stb cycle on the bus,
// one response (read data or timeout error) out.
module wb_host_initiator #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        to_hit;

   // Counter value during the last permitted stb cycle; TIMEOUT=0 disables the check.
   always_comb begin
      to_hit = 1'b0;
      if (TIMEOUT != 0)
         to_hit = (cnt == TO_LAST);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid_i)          state_nxt = BUS;
         BUS:     if (wbm_ack_i || to_hit)  state_nxt = RESP;
         RESP:    if (rsp_ready_i)          state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o = (state == IDLE);
      busy_o      = (state != IDLE);
   end

   // Registered bus and response outputs; ack takes priority over a coincident timeout.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= '0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= cmd_we_i;
                  wbm_sel_o <= cmd_sel_i;
                  wbm_adr_o <= cmd_adr_i;
                  wbm_dat_o <= cmd_dat_i;
                  cnt       <= '0;
               end
            end
            BUS: begin
               if (cnt != 16'hFFFF)
                  cnt <= cnt + 16'd1;
               if (wbm_ack_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
               end else if (to_hit) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_dat_o   <= '0;
               end
            end
            RESP: begin
               if (rsp_ready_i)
                  rsp_valid_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator (TIMEOUT=8); the bench plays the Wishbone slave.
module tb_wb_host_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack = 1'b0;
   logic [31:0] rdat = '0;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;

   wb_host_initiator #(.TIMEOUT(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tests_run++; if ({cyc, stb, we} !== 3'b000) begin tests_failed++; $display("FAIL reset_bus got %b exp 000", {cyc, stb, we}); end
      tests_run++; if ({rsp_valid, rsp_err, busy, cmd_ready} !== 4'b0001) begin tests_failed++; $display("FAIL reset_ctl got %b exp 0001", {rsp_valid, rsp_err, busy, cmd_ready}); end
      tests_run++; if ({adr, wdat, rsp_dat, sel} !== 100'd0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", {adr, wdat, rsp_dat, sel}); end
   endtask

   task automatic test_write();
      rsp_ready = 1'b1;
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_ready got %b exp 1", cmd_ready); end
      issue(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF);
      tests_run++; if ({cyc, stb, we, sel, busy, cmd_ready} !== 9'b111_1111_10) begin tests_failed++; $display("FAIL wr_bus got %b exp 111111110", {cyc, stb, we, sel, busy, cmd_ready}); end
      tests_run++; if ({adr, wdat} !== {32'h3000_0004, 32'hA5A5_0001}) begin tests_failed++; $display("FAIL wr_adr_dat got %h exp 30000004a5a50001", {adr, wdat}); end
      tick();
      tests_run++; if ({cyc, stb, rsp_valid} !== 3'b110) begin tests_failed++; $display("FAIL wr_hold got %b exp 110", {cyc, stb, rsp_valid}); end
      tick();
      ack = 1'b1; rdat = 32'hDEAD_BEEF;
      tick();
      ack = 1'b0;
      tests_run++; if ({rsp_valid, rsp_err, cyc, stb} !== 4'b1000) begin tests_failed++; $display("FAIL wr_rsp got %b exp 1000", {rsp_valid, rsp_err, cyc, stb}); end
      tests_run++; if (rsp_dat !== 32'd0) begin tests_failed++; $display("FAIL wr_rsp_dat got %h exp 0", rsp_dat); end
      tick();
      tests_run++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin tests_failed++; $display("FAIL wr_done got %b exp 010", {rsp_valid, cmd_ready, busy}); end
   endtask

   task automatic test_read();
      rsp_ready = 1'b1;
      issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      tests_run++; if ({cyc, stb, we} !== 3'b110) begin tests_failed++; $display("FAIL rd_bus got %b exp 110", {cyc, stb, we}); end
      ack = 1'b1; rdat = 32'h0000_002A;
      tick();
      ack = 1'b0; rdat = 32'h0;
      tests_run++; if ({rsp_valid, rsp_err, cyc, stb, cmd_ready} !== 5'b10000) begin tests_failed++; $display("FAIL rd_rsp got %b exp 10000", {rsp_valid, rsp_err, cyc, stb, cmd_ready}); end
      tests_run++; if (rsp_dat !== 32'h0000_002A) begin tests_failed++; $display("FAIL rd_dat got %h exp 0000002a", rsp_dat); end
      tick();
      tests_run++; if ({cmd_ready, rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL rd_turnaround got %b exp 10", {cmd_ready, rsp_valid}); end
   endtask

   task automatic test_timeout();
      int stb_cycles = 0;
      rsp_ready = 1'b1;
      rdat = 32'hFFFF_FFFF;
      issue(1'b0, 32'h3000_0008, 32'h0, 4'h3);
      for (int i = 0; i < 20; i++) begin
         if (stb !== 1'b1) break;
         stb_cycles++;
         tick();
      end
      tests_run++; if (stb_cycles != 8) begin tests_failed++; $display("FAIL to_stb_len got %0d exp 8", stb_cycles); end
      tests_run++; if ({rsp_valid, rsp_err, cyc} !== 3'b110) begin tests_failed++; $display("FAIL to_rsp got %b exp 110", {rsp_valid, rsp_err, cyc}); end
      tests_run++; if (rsp_dat !== 32'd0) begin tests_failed++; $display("FAIL to_dat got %h exp 0", rsp_dat); end
      rdat = 32'h0;
      tick();
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL to_ready got %b exp 1", cmd_ready); end
      issue(1'b1, 32'h3000_000C, 32'h1234_5678, 4'h1);
      tests_run++; if ({cyc, stb, we, sel} !== 7'b111_0001) begin tests_failed++; $display("FAIL to_next_cmd got %b exp 1110001", {cyc, stb, we, sel}); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tests_run++; if ({rsp_valid, rsp_err} !== 2'b10) begin tests_failed++; $display("FAIL to_next_rsp got %b exp 10", {rsp_valid, rsp_err}); end
      tick();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      ack = 1'b1; rdat = 32'h1234_5678;
      tick();
      ack = 1'b0; rdat = 32'h0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if ({rsp_valid, cmd_ready, cyc} !== 3'b100 || rsp_dat !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL bp_hold%0d got v/rdy/cyc %b dat %h exp 100 12345678", i, {rsp_valid, cmd_ready, cyc}, rsp_dat);
         end
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      tests_run++; if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin tests_failed++; $display("FAIL bp_release got %b exp 010", {rsp_valid, cmd_ready, cyc}); end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b1;
      issue(1'b1, 32'h3000_0014, 32'hCAFE_0000, 4'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++; if ({cyc, stb, busy, cmd_ready, rsp_valid} !== 5'b00010) begin tests_failed++; $display("FAIL rstmid_drop got %b exp 00010", {cyc, stb, busy, cmd_ready, rsp_valid}); end
      ack = 1'b1; rdat = 32'h0000_00AA;
      tick();
      ack = 1'b0;
      tick();
      tests_run++; if ({cyc, busy, rsp_valid} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_late_ack got %b exp 000", {cyc, busy, rsp_valid}); end
   endtask

   task automatic test_ack_edges();
      rsp_ready = 1'b1;
      ack = 1'b1; rdat = 32'h0000_0055;
      tick(); tick();
      ack = 1'b0;
      tests_run++; if ({busy, rsp_valid, cyc} !== 3'b000) begin tests_failed++; $display("FAIL idle_ack got %b exp 000", {busy, rsp_valid, cyc}); end
      issue(1'b0, 32'h3000_0018, 32'h0, 4'hF);
      for (int i = 0; i < 7; i++) tick();
      tests_run++; if (stb !== 1'b1) begin tests_failed++; $display("FAIL last_stb got %b exp 1", stb); end
      ack = 1'b1; rdat = 32'h0000_0077;
      tick();
      ack = 1'b0;
      tests_run++; if ({rsp_valid, rsp_err, stb} !== 3'b100) begin tests_failed++; $display("FAIL to_ack_win got %b exp 100", {rsp_valid, rsp_err, stb}); end
      tests_run++; if (rsp_dat !== 32'h0000_0077) begin tests_failed++; $display("FAIL to_ack_dat got %h exp 00000077", rsp_dat); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_ack_edges();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
